// File: rtl/loteria_pkg.sv
// Shared state encoding, ticket geometry and prize codes for the lottery scheduler.
package loteria_pkg;

    localparam int DIGIT_W   = 4;
    localparam int TICKET_W  = 20;
    localparam int N_DIGITS  = 5;
    localparam int MAX_DIGIT = 9;

    localparam logic [1:0] PRIZE_NONE = 2'd0;
    localparam logic [1:0] PRIZE_P1   = 2'd1;
    localparam logic [1:0] PRIZE_P2   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_CLEAR,
        S_INS,
        S_GAP,
        S_FINISH,
        S_WAIT,
        S_RESPOND
    } state_t;

endpackage

// File: rtl/loteria_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module loteria_rr_arbiter
    import loteria_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int ID_W      = $clog2(N_PLAYERS)
) (
    input  logic [N_PLAYERS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [N_PLAYERS-1:0] grant,
    output logic [ID_W-1:0]      grant_idx
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_PLAYERS) cand = cand - N_PLAYERS;
            cand_idx = cand[ID_W-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/loteria_scheduler.sv
// Round-robin scheduler sharing one lottery checker between N_PLAYERS stations.
// Define LOTERIA_STATS_EN to add saturating served_cnt / win_cnt outputs.
module loteria_scheduler
    import loteria_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int ID_W      = $clog2(N_PLAYERS),
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PLAYERS-1:0]          req,
    input  logic [TICKET_W*N_PLAYERS-1:0] ticket,
    output logic [N_PLAYERS-1:0]          ack,
    output logic [1:0]                    prize,
    output logic                          err,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
`ifdef LOTERIA_STATS_EN
    output logic [15:0]                   served_cnt,
    output logic [15:0]                   win_cnt,
`endif
    output logic                          chk_clear,
    output logic [3:0]                    chk_num,
    output logic                          chk_insert,
    output logic                          chk_finish,
    input  logic                          chk_done,
    input  logic [1:0]                    chk_prize
);

    function automatic logic bad_digit(input logic [TICKET_W-1:0] t);
        logic b;
        b = 1'b0;
        for (int k = 0; k < N_DIGITS; k++)
            if (t[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) b = 1'b1;
        return b;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_at(input logic [TICKET_W-1:0] t,
                                                   input logic [2:0] k);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (k == 3'(i)) d = t[i*DIGIT_W +: DIGIT_W];
        return d;
    endfunction

    function automatic logic [N_PLAYERS-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N_PLAYERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                 state;
    logic [ID_W-1:0]        ptr;
    logic [2:0]             dig;
    logic [7:0]             wait_cnt;
    logic [TICKET_W-1:0]    ticket_q;
    logic [TICKET_W-1:0]    sel_ticket;
    logic [N_PLAYERS-1:0]   arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   req_any;

    loteria_rr_arbiter #(
        .N_PLAYERS (N_PLAYERS),
        .ID_W      (ID_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_any = |arb_grant;

    always_comb begin
        sel_ticket = '0;
        for (int p = 0; p < N_PLAYERS; p++)
            if (arb_grant[p]) sel_ticket = ticket[p*TICKET_W +: TICKET_W];
    end

    // Ticket is captured once at grant; later changes on the input are ignored.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_any) ticket_q <= sel_ticket;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            dig        <= '0;
            wait_cnt   <= '0;
            ack        <= '0;
            prize      <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            chk_clear  <= 1'b0;
            chk_num    <= '0;
            chk_insert <= 1'b0;
            chk_finish <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        grant_id <= arb_idx;
                        busy     <= 1'b1;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bad_digit(ticket_q)) begin
                        ack   <= onehot(grant_id);
                        prize <= PRIZE_NONE;
                        err   <= 1'b1;
                        state <= S_RESPOND;
                    end else begin
                        chk_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    chk_clear  <= 1'b0;
                    chk_num    <= digit_at(ticket_q, 3'd0);
                    chk_insert <= 1'b1;
                    dig        <= '0;
                    state      <= S_INS;
                end
                S_INS: begin
                    chk_insert <= 1'b0;
                    state      <= S_GAP;
                end
                S_GAP: begin
                    if (dig == 3'(N_DIGITS-1)) begin
                        chk_finish <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        dig        <= dig + 3'd1;
                        chk_num    <= digit_at(ticket_q, dig + 3'd1);
                        chk_insert <= 1'b1;
                        state      <= S_INS;
                    end
                end
                S_FINISH: begin
                    chk_finish <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final WAIT cycle takes priority over the timeout.
                    if (chk_done) begin
                        ack   <= onehot(grant_id);
                        prize <= chk_prize;
                        err   <= 1'b0;
                        state <= S_RESPOND;
                    end else if (wait_cnt == 8'(TIMEOUT-1)) begin
                        ack   <= onehot(grant_id);
                        prize <= PRIZE_NONE;
                        err   <= 1'b1;
                        state <= S_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESPOND: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (grant_id == ID_W'(N_PLAYERS-1)) ? '0 : grant_id + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOTERIA_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_cnt <= '0;
            win_cnt    <= '0;
        end else if (|ack) begin
            if (served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
            if (prize != PRIZE_NONE && !err && win_cnt != 16'hFFFF)
                win_cnt <= win_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_loteria_scheduler.sv
// Randomized self-checking bench for loteria_scheduler with a transaction-level reference model.
module tb_loteria_scheduler;
    import loteria_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [TW*N-1:0] ticket;
    logic [N-1:0]  ack;
    logic [1:0]    prize;
    logic          err;
    logic          busy;
    logic [1:0]    grant_id;
    logic          chk_clear;
    logic [3:0]    chk_num;
    logic          chk_insert;
    logic          chk_finish;
    logic          chk_done;
    logic [1:0]    chk_prize;
`ifdef LOTERIA_STATS_EN
    logic [15:0]   served_cnt;
    logic [15:0]   win_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;
    int m_served = 0;
    int m_win    = 0;
    int dut_g    = 0;

    always #5 clk = ~clk;

    loteria_scheduler #(
        .N_PLAYERS (N),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ticket     (ticket),
        .ack        (ack),
        .prize      (prize),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
`ifdef LOTERIA_STATS_EN
        .served_cnt (served_cnt),
        .win_cnt    (win_cnt),
`endif
        .chk_clear  (chk_clear),
        .chk_num    (chk_num),
        .chk_insert (chk_insert),
        .chk_finish (chk_finish),
        .chk_done   (chk_done),
        .chk_prize  (chk_prize)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_ticket();
        logic [TW-1:0] t;
        int j;
        for (int i = 0; i < 5; i++) t[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) begin
            j = $urandom_range(0, 4);
            t[4*j +: 4] = 4'($urandom_range(10, 15));
        end
        return t;
    endfunction

    // One service: the model picks the winner, predicts timing and result, then watches the DUT.
    // d = extra WAIT cycles before the checker answers; abort_at = cycle to pull reset (0 = never).
    task automatic serve(input int d, input logic [1:0] cprize, input int abort_at);
        int g, kf, kack, nclr, nins, nfin, waitc, exp_ack_k;
        logic [TW-1:0] tk;
        bit bad, exp_err, drive;
        logic [1:0] exp_prize;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int p;
            p = (ptr_m + i) % N;
            if (g < 0 && req[p]) g = p;
        end
        if (g < 0) begin
            check_val("no_request", 0, 1);
            return;
        end
        tk  = ticket[g*TW +: TW];
        bad = 1'b0;
        for (int i = 0; i < 5; i++) if (tk[4*i +: 4] > 4'd9) bad = 1'b1;
        if (bad) begin
            exp_ack_k = 2;
            exp_err   = 1'b1;
            exp_prize = 2'd0;
        end else begin
            waitc     = (d + 1 <= TO) ? d + 1 : TO;
            exp_ack_k = 14 + waitc;
            exp_err   = (d + 1 > TO);
            exp_prize = exp_err ? 2'd0 : cprize;
        end
        kf = -1; kack = -1; nclr = 0; nins = 0; nfin = 0;
        for (int k = 1; k <= 60 && kack < 0; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                check_val("ins3_live", int'(chk_insert), 1);
                #2 reset = 1'b0;
                #1;
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_insert", int'(chk_insert), 0);
                check_val("rst_grant_id", int'(grant_id), 0);
                check_val("rst_ack", int'(ack), 0);
                chk_done = 1'b0;
                ptr_m = 0; m_served = 0; m_win = 0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (k == 1) begin
                check_val("grant_busy", int'(busy), 1);
                check_val("grant_id", int'(grant_id), g);
                dut_g = int'(grant_id);
            end
            if (chk_clear) begin
                check_val("clear_cycle", k, 2);
                nclr++;
            end
            if (chk_insert) begin
                check_val("insert_cycle", k, 3 + 2*nins);
                if (nins < 5) check_val("insert_digit", int'(chk_num), int'(tk[4*nins +: 4]));
                nins++;
            end
            if (!bad && k >= 4 && k <= 12 && (k % 2) == 0) begin
                check_val("gap_strobe", int'(chk_insert), 0);
                check_val("gap_digit", int'(chk_num), int'(tk[4*((k-4)/2) +: 4]));
            end
            if (chk_finish) begin
                check_val("finish_cycle", k, 13);
                kf = k;
                nfin++;
            end
            if (|ack) begin
                kack = k;
                check_val("ack_cycle", k, exp_ack_k);
                check_val("ack_onehot", int'(ack), 1 << g);
                check_val("prize", int'(prize), int'(exp_prize));
                check_val("err", int'(err), int'(exp_err));
            end
            if (k == 2) begin
                for (int p = 0; p < N; p++) ticket[p*TW +: TW] = rand_ticket();
                if ($urandom_range(0, 1) == 1) req[g] = 1'b0;
            end
            drive     = (kf > 0 && k == kf + 1 + d);
            chk_done  = drive;
            chk_prize = drive ? cprize : 2'($urandom_range(0, 3));
        end
        chk_done = 1'b0;
        if (kack < 0) begin
            check_val("ack_budget", 0, 1);
            return;
        end
        check_val("clear_count", nclr, bad ? 0 : 1);
        check_val("insert_count", nins, bad ? 0 : 5);
        check_val("finish_count", nfin, bad ? 0 : 1);
        ptr_m = (g + 1) % N;
        req[g] = 1'b0;
        m_served++;
        if (exp_prize != 2'd0 && !exp_err) m_win++;
        @(negedge clk);
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_ack", int'(ack), 0);
        check_val("prize_hold", int'(prize), int'(exp_prize));
        check_val("err_hold", int'(err), int'(exp_err));
`ifdef LOTERIA_STATS_EN
        check_val("served_cnt", int'(served_cnt), m_served);
        check_val("win_cnt", int'(win_cnt), m_win);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, d;
        reset = 1'b0; req = '0; ticket = '0; chk_done = 1'b0; chk_prize = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ack0", int'(ack), 0);
        check_val("rst_prize0", int'(prize), 0);
        check_val("rst_err0", int'(err), 0);
        check_val("rst_busy0", int'(busy), 0);
        check_val("rst_gid0", int'(grant_id), 0);
        check_val("rst_clear0", int'(chk_clear), 0);
        check_val("rst_insert0", int'(chk_insert), 0);
        check_val("rst_finish0", int'(chk_finish), 0);
        check_val("rst_num0", int'(chk_num), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int p = 0; p < N; p++) ticket[p*TW +: TW] = rand_ticket();
        req = '1;
        for (int i = 0; i < N; i++) begin
            serve(0, PRIZE_P1, 0);
            check_val("rr_order", dut_g, i);
        end
        req = 4'b0101;
        serve(0, PRIZE_P2, 0);
        check_val("rr_held_first", dut_g, 0);
        serve(0, PRIZE_P2, 0);
        check_val("rr_held_second", dut_g, 2);

        ticket[19:0] = 20'h76905;
        req = 4'b0001;
        serve(0, PRIZE_P1, 0);

        ticket[39:20] = 20'h50A21;
        req = 4'b0010;
        serve(0, PRIZE_P1, 0);

        ticket[59:40] = 20'h12345;
        req = 4'b0100;
        serve(1000, PRIZE_P2, 0);
        ticket[59:40] = 20'h12345;
        req = 4'b0100;
        serve(TO - 1, PRIZE_P2, 0);

        ticket[39:20] = 20'h11111;
        req = 4'b0010;
        serve(0, PRIZE_P1, 0);
        ticket[79:60] = 20'h98765;
        req = 4'b1000;
        serve(0, PRIZE_P1, 9);

        ticket[39:20] = 20'h24680;
        ticket[79:60] = 20'h13579;
        req = 4'b1010;
        serve(0, PRIZE_P1, 0);
        check_val("post_rst_grant", dut_g, 1);
        ticket[79:60] = 20'h13579;
        serve(0, PRIZE_NONE, 0);
        ticket[19:0] = 20'hF0000;
        req = 4'b0001;
        serve(0, PRIZE_P1, 0);
`ifdef LOTERIA_STATS_EN
        check_val("stats_served3", int'(served_cnt), 3);
        check_val("stats_win1", int'(win_cnt), 1);
`endif

        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < N; p++) ticket[p*TW +: TW] = rand_ticket();
            req = req | N'($urandom);
            if (req == '0) req[$urandom_range(0, N-1)] = 1'b1;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      d = $urandom_range(0, 3);
            else if (sel == 6) d = TO - 1;
            else if (sel == 7) d = TO;
            else if (sel == 8) d = TO - 2;
            else               d = 1000;
            serve(d, 2'($urandom_range(0, 3)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loteria_scheduler.md
Name: loteria_scheduler

Overview:
- Shares one lottery checker datapath between N_PLAYERS player stations.
- Arbitrates requests round-robin and latches the granted player's 5-digit ticket.
- Sequences the checker: clear, five digit inserts, finish, wait for result.
- Returns prize and error status to the granted player with a one-cycle ack.

Parameters:
- N_PLAYERS, 4, number of requesting stations (2..8).
- ID_W, $clog2(N_PLAYERS), width of grant_id.
- TIMEOUT, 255, maximum WAIT cycles for chk_done before error (1..255).

Ports:
- clk  in  1  clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_PLAYERS  level request per player, held until its ack.
- ticket  in  20*N_PLAYERS  player p uses ticket[20p+:20]; digit k is bits [4k+3:4k]; digit0 is entered first.
- ack  out  N_PLAYERS  one-cycle pulse to the served player.
- prize  out  2  prize code, valid with ack: 0=none, 1=P1, 2=P2.
- err  out  1  valid with ack: invalid digit or checker timeout.
- busy  out  1  high in every state except IDLE.
- grant_id  out  ID_W  index of the current or last granted player.
- chk_clear  out  1  one-cycle active-high clear pulse to the checker.
- chk_num  out  4  digit presented to the checker.
- chk_insert  out  1  digit strobe.
- chk_finish  out  1  finish strobe.
- chk_done  in  1  checker result valid.
- chk_prize  in  2  checker prize code, sampled when chk_done=1.

Behaviour:
- Reset (reset=0, async): state IDLE; RR pointer 0; all outputs 0; counters 0.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping.
  - Latch that player's ticket and grant_id; go to GRANT.
  - Requests are sampled only in IDLE.
- GRANT:
  - If any latched digit > 9, go to RESPOND with err=1, prize=0. The checker is untouched.
  - Otherwise go to CLEAR.
- CLEAR: chk_clear=1 for one cycle; go to INS0.
- INSk, k=0..4:
  - chk_num=digit k, chk_insert=1 for one cycle; go to GAPk.
  - GAPk: chk_insert=0 and chk_num holds for one cycle.
  - After GAP4, go to FINISH.
- FINISH: chk_finish=1 for one cycle; reset the wait counter; go to WAIT.
- WAIT:
  - On chk_done=1, capture chk_prize and set err=0; go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT, set err=1, prize=0 and go to RESPOND.
  - If chk_done and the timeout occur in the same cycle, chk_done wins.
- RESPOND:
  - ack[grant_id]=1 for exactly one cycle; prize and err are valid.
  - Pointer becomes (grant_id+1) mod N_PLAYERS; go to IDLE.
- Latency: with GRANT at cycle t and chk_done on the first WAIT cycle, the sequence is CLEAR t+1, inserts at t+2/4/6/8/10, FINISH t+12, WAIT t+13, ack t+14.
- Invalid ticket: ack at t+1.
- Outside RESPOND, prize and err hold their last values; ack is 0.
- req dropped mid-service: service completes and ack still pulses.
- Ticket changes after grant are ignored.
- Reset mid-operation: immediate return to IDLE; all strobes drop asynchronously.
- chk_prize value 3 is passed through unchanged.

Optional Feature:
- Macro: LOTERIA_STATS_EN.
- When defined, adds outputs served_cnt[15:0] and win_cnt[15:0].
  - served_cnt increments on every ack.
  - win_cnt increments on every ack with prize!=0 and err=0.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package loteria_pkg holds:
  - state encoding enum;
  - DIGIT_W=4, TICKET_W=20, N_DIGITS=5, MAX_DIGIT=9;
  - prize codes PRIZE_NONE/P1/P2.
- Sub-module loteria_rr_arbiter:
  - combinational grant from req and pointer, producing a one-hot grant and a grant index;
  - the pointer register stays in the scheduler.

Test Plan:
- Single player, P0 ticket digits 5,0,9,6,7; checker model asserts chk_done one cycle after finish with prize 1. Required:
  - chk_num sequence 5,0,9,6,7 on alternating cycles;
  - ack[0] at GRANT+14 with prize=1, err=0.
- All four req high. Required:
  - grants in order 0,1,2,3;
  - then req0 and req2 held, giving grant 0 next and then 2.
- Player 1 ticket with digit2=4'hA. Required:
  - ack[1] at GRANT+1 with err=1, prize=0;
  - no chk_clear, chk_insert or chk_finish pulse.
- TIMEOUT=8, checker never asserts done. Required:
  - ack after 8 WAIT cycles with err=1, prize=0;
  - chk_done and timeout coincident gives err=0.
- reset low during INS3. Required:
  - busy, chk_insert and grant_id drop to 0 without a clock edge;
  - after release, pointer=0 and a fresh request is served normally.
- LOTERIA_STATS_EN defined, three tickets (prize 1, prize 0, invalid digit). Required: served_cnt=3, win_cnt=1.
